// File: rtl/i2c_slave_regfile.sv
// I2C target with an oversampled, synchronised SCL/SDA front end and a byte register file.
// Supports multi-byte auto-increment, repeated START, master ACK/NACK on reads and a host peek port.
module i2c_slave_regfile #(
    parameter logic [6:0]  SLV_ADDR    = 7'h01,
    parameter int unsigned NUM_REGS    = 16,
    parameter int unsigned SYNC_STAGES = 2,
    localparam int unsigned REG_AW     = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              SCL,
    inout  logic              SDA,
    output logic              wr_stb,
    output logic [REG_AW-1:0] wr_addr,
    output logic [7:0]        wr_data,
    input  logic [REG_AW-1:0] host_addr,
    output logic [7:0]        host_rdata,
    output logic              busy
);

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_REG,
        ST_REG_ACK,
        ST_WDATA,
        ST_WDATA_ACK,
        ST_RDATA,
        ST_RDATA_ACK,
        ST_RLOAD
    } state_t;

    logic [SYNC_STAGES-1:0] r_scl_sync;
    logic [SYNC_STAGES-1:0] r_sda_sync;
    logic                   r_scl_d;
    logic                   r_sda_d;

    state_t             r_state;
    logic [2:0]         r_bitcnt;
    logic [7:0]         r_shift;
    logic [7:0]         r_tx;
    logic               r_rw;
    logic               r_sda_oe;
    logic               r_busy;
    logic [REG_AW-1:0]  r_ptr;
    logic [7:0]         r_regs [NUM_REGS];
    logic               r_wr_stb;
    logic [REG_AW-1:0]  r_wr_addr;
    logic [7:0]         r_wr_data;
    logic [7:0]         r_host_rdata;

    logic               w_scl;
    logic               w_sda;
    logic               w_rise;
    logic               w_fall;
    logic               w_start;
    logic               w_stop;
    logic [7:0]         w_byte;
    logic [REG_AW-1:0]  w_ptr_inc;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_scl_sync <= '1;
            r_sda_sync <= '1;
            r_scl_d    <= 1'b1;
            r_sda_d    <= 1'b1;
        end else begin
            r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], SCL};
            r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], SDA};
            r_scl_d    <= w_scl;
            r_sda_d    <= w_sda;
        end
    end

    assign w_scl  = r_scl_sync[SYNC_STAGES-1];
    assign w_sda  = r_sda_sync[SYNC_STAGES-1];
    assign w_rise = ~r_scl_d & w_scl;
    assign w_fall = r_scl_d & ~w_scl;
    // START/STOP qualify on the previous SCL level so a coincident SCL edge cannot mask or fake one
    assign w_start = r_scl_d & r_sda_d & ~w_sda;
    assign w_stop  = r_scl_d & ~r_sda_d & w_sda;

    assign w_byte    = {r_shift[6:0], w_sda};
    assign w_ptr_inc = (r_ptr == REG_AW'(NUM_REGS - 1)) ? '0 : r_ptr + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_bitcnt  <= '0;
            r_shift   <= '0;
            r_tx      <= '0;
            r_rw      <= 1'b0;
            r_sda_oe  <= 1'b0;
            r_busy    <= 1'b0;
            r_ptr     <= '0;
            r_wr_stb  <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            r_wr_stb <= 1'b0;
            if (w_start) begin
                r_state  <= ST_ADDR;
                r_bitcnt <= '0;
                r_busy   <= 1'b1;
                r_sda_oe <= 1'b0;
            end else if (w_stop) begin
                r_state  <= ST_IDLE;
                r_busy   <= 1'b0;
                r_sda_oe <= 1'b0;
            end else begin
                case (r_state)
                    ST_ADDR, ST_REG, ST_WDATA: begin
                        if (w_rise) begin
                            r_shift  <= w_byte;
                            r_bitcnt <= r_bitcnt + 1'b1;
                            if (r_bitcnt == 3'd7) begin
                                if (r_state == ST_ADDR) begin
                                    if (w_byte[7:1] == SLV_ADDR) begin
                                        r_rw    <= w_byte[0];
                                        r_state <= ST_ADDR_ACK;
                                    end else begin
                                        r_state <= ST_IDLE;
                                        r_busy  <= 1'b0;
                                    end
                                end else if (r_state == ST_REG) begin
                                    if (32'(w_byte) < NUM_REGS) begin
                                        r_ptr   <= w_byte[REG_AW-1:0];
                                        r_state <= ST_REG_ACK;
                                    end else begin
                                        r_state <= ST_IDLE;
                                        r_busy  <= 1'b0;
                                    end
                                end else begin
                                    r_regs[r_ptr] <= w_byte;
                                    r_wr_stb      <= 1'b1;
                                    r_wr_addr     <= r_ptr;
                                    r_wr_data     <= w_byte;
                                    r_ptr         <= w_ptr_inc;
                                    r_state       <= ST_WDATA_ACK;
                                end
                            end
                        end
                    end
                    ST_ADDR_ACK, ST_REG_ACK, ST_WDATA_ACK: begin
                        // first fall starts the ACK slot, second fall ends it
                        if (w_fall) begin
                            if (!r_sda_oe) begin
                                r_sda_oe <= 1'b1;
                            end else if (r_state == ST_ADDR_ACK && r_rw) begin
                                r_tx     <= r_regs[r_ptr];
                                r_sda_oe <= ~r_regs[r_ptr][7];
                                r_state  <= ST_RDATA;
                            end else begin
                                r_sda_oe <= 1'b0;
                                r_state  <= (r_state == ST_ADDR_ACK) ? ST_REG : ST_WDATA;
                            end
                        end
                    end
                    ST_RDATA: begin
                        if (w_fall) begin
                            r_tx     <= {r_tx[6:0], 1'b0};
                            r_sda_oe <= ~r_tx[6];
                        end else if (w_rise) begin
                            r_bitcnt <= r_bitcnt + 1'b1;
                            if (r_bitcnt == 3'd7) begin
                                r_state <= ST_RDATA_ACK;
                            end
                        end
                    end
                    ST_RDATA_ACK: begin
                        if (w_fall) begin
                            r_sda_oe <= 1'b0;
                        end else if (w_rise) begin
                            if (!w_sda) begin
                                r_ptr   <= w_ptr_inc;
                                r_state <= ST_RLOAD;
                            end else begin
                                r_state <= ST_IDLE;
                                r_busy  <= 1'b0;
                            end
                        end
                    end
                    ST_RLOAD: begin
                        if (w_fall) begin
                            r_tx     <= r_regs[r_ptr];
                            r_sda_oe <= ~r_regs[r_ptr][7];
                            r_state  <= ST_RDATA;
                        end
                    end
                    default: begin
                        r_sda_oe <= 1'b0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_host_rdata <= '0;
        end else if (32'(host_addr) < NUM_REGS) begin
            r_host_rdata <= r_regs[host_addr];
        end else begin
            r_host_rdata <= '0;
        end
    end

    assign SDA        = r_sda_oe ? 1'b0 : 1'bz;
    assign wr_stb     = r_wr_stb;
    assign wr_addr    = r_wr_addr;
    assign wr_data    = r_wr_data;
    assign host_rdata = r_host_rdata;
    assign busy       = r_busy;

endmodule

// File: tb/tb_i2c_slave_regfile.sv
// Directed bench for i2c_slave_regfile: bit-banged I2C master, write-strobe logger, host peeks.
module tb_i2c_slave_regfile;

    localparam int Q = 4;

    logic       clk;
    logic       rst;
    logic       SCL;
    logic       m_low;
    wire        SDA;
    logic       wr_stb;
    logic [3:0] wr_addr;
    logic [7:0] wr_data;
    logic [3:0] host_addr;
    logic [7:0] host_rdata;
    logic       busy;

    int n_chk  = 0;
    int n_pass = 0;
    int stb_cnt = 0;
    logic [3:0] log_addr [32];
    logic [7:0] log_data [32];

    pullup (SDA);
    assign SDA = m_low ? 1'b0 : 1'bz;

    i2c_slave_regfile #(
        .SLV_ADDR    (7'h01),
        .NUM_REGS    (16),
        .SYNC_STAGES (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .SCL        (SCL),
        .SDA        (SDA),
        .wr_stb     (wr_stb),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .host_addr  (host_addr),
        .host_rdata (host_rdata),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (wr_stb === 1'b1) begin
            if (stb_cnt < 32) begin
                log_addr[stb_cnt] = wr_addr;
                log_data[stb_cnt] = wr_data;
            end
            stb_cnt++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        else n_pass++;
    endtask

    task automatic wait_q();
        repeat (Q) @(negedge clk);
    endtask

    task automatic bit_cycle(input logic drive_low, output logic sampled);
        wait_q(); m_low = drive_low;
        wait_q(); SCL = 1'b1;
        wait_q(); sampled = SDA;
        wait_q(); SCL = 1'b0;
    endtask

    task automatic i2c_start();
        wait_q(); m_low = 1'b0;
        wait_q(); SCL = 1'b1;
        wait_q(); m_low = 1'b1;
        wait_q(); SCL = 1'b0;
    endtask

    task automatic i2c_stop();
        wait_q(); m_low = 1'b1;
        wait_q(); SCL = 1'b1;
        wait_q(); m_low = 1'b0;
        wait_q();
    endtask

    task automatic send_bits(input logic [7:0] b, input int n);
        logic s;
        for (int i = 7; i > 7 - n; i--) bit_cycle(~b[i], s);
    endtask

    task automatic write_byte(input logic [7:0] b, output logic nack);
        send_bits(b, 8);
        bit_cycle(1'b0, nack);
    endtask

    task automatic read_byte(input logic nack, output logic [7:0] b);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            bit_cycle(1'b0, s);
            b[i] = s;
        end
        bit_cycle(~nack, s);
    endtask

    task automatic peek(input logic [3:0] a, input logic [7:0] exp, input string tag);
        host_addr = a;
        repeat (2) @(negedge clk);
        check(tag, host_rdata, exp);
    endtask

    logic       ack;
    logic [7:0] rd;

    initial begin
        rst = 1'b1; SCL = 1'b1; m_low = 1'b0; host_addr = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_stb", wr_stb, 0);
        check("rst_waddr", wr_addr, 0);
        check("rst_wdata", wr_data, 0);
        check("rst_host", host_rdata, 0);
        check("rst_sda", SDA, 1);

        // single write reg 3 = 0xA5
        i2c_start();
        check("t1_busy", busy, 1);
        write_byte(8'h02, ack); check("t1_ack_addr", ack, 0);
        write_byte(8'h03, ack); check("t1_ack_reg", ack, 0);
        write_byte(8'hA5, ack); check("t1_ack_data", ack, 0);
        i2c_stop();
        check("t1_busy_end", busy, 0);
        check("t1_stb_cnt", stb_cnt, 1);
        check("t1_waddr", log_addr[0], 3);
        check("t1_wdata", log_data[0], 8'hA5);
        peek(4'd3, 8'hA5, "t1_peek3");

        // reg 1 = 0x5A, later read back through the wrapped pointer
        i2c_start();
        write_byte(8'h02, ack); write_byte(8'h01, ack); write_byte(8'h5A, ack);
        i2c_stop();

        // burst with wrap 14,15,0
        i2c_start();
        write_byte(8'h02, ack); write_byte(8'h0E, ack);
        write_byte(8'h11, ack); check("t2_ack1", ack, 0);
        write_byte(8'h22, ack); check("t2_ack2", ack, 0);
        write_byte(8'h33, ack); check("t2_ack3", ack, 0);
        i2c_stop();
        check("t2_stb_cnt", stb_cnt, 5);
        check("t2_a0", log_addr[2], 14); check("t2_d0", log_data[2], 8'h11);
        check("t2_a1", log_addr[3], 15); check("t2_d1", log_data[3], 8'h22);
        check("t2_a2", log_addr[4], 0);  check("t2_d2", log_data[4], 8'h33);
        peek(4'd14, 8'h11, "t2_peek14");
        peek(4'd15, 8'h22, "t2_peek15");
        peek(4'd0, 8'h33, "t2_peek0");
        i2c_start();
        write_byte(8'h03, ack); check("t2_rd_ack", ack, 0);
        read_byte(1'b1, rd); check("t2_rd_ptr1", rd, 8'h5A);
        i2c_stop();

        // foreign address and out-of-range register
        i2c_start();
        write_byte(8'h04, ack); check("t3_nak_addr", ack, 1);
        check("t3_busy_addr", busy, 0);
        write_byte(8'h00, ack); check("t3_nodrive", ack, 1);
        i2c_stop();
        i2c_start();
        write_byte(8'h02, ack); check("t3_ack_addr", ack, 0);
        write_byte(8'h10, ack); check("t3_nak_reg", ack, 1);
        check("t3_busy_reg", busy, 0);
        i2c_stop();
        check("t3_stb_cnt", stb_cnt, 5);
        i2c_start();
        write_byte(8'h03, ack);
        read_byte(1'b1, rd); check("t3_ptr_kept", rd, 8'h5A);
        i2c_stop();
        peek(4'd3, 8'hA5, "t3_peek3");

        // preload then combined write-pointer / repeated START / read
        i2c_start();
        write_byte(8'h02, ack); write_byte(8'h05, ack);
        write_byte(8'h3C, ack); write_byte(8'hC3, ack);
        i2c_stop();
        check("t4_stb_cnt", stb_cnt, 7);
        i2c_start();
        write_byte(8'h02, ack); write_byte(8'h05, ack);
        i2c_start();
        write_byte(8'h03, ack); check("t4_ack_rd", ack, 0);
        read_byte(1'b0, rd); check("t4_rd0", rd, 8'h3C);
        read_byte(1'b1, rd); check("t4_rd1", rd, 8'hC3);
        wait_q();
        check("t4_sda_rel", SDA, 1);
        check("t4_busy", busy, 0);
        i2c_stop();

        // STOP after 4 data bits discards the byte
        i2c_start();
        write_byte(8'h02, ack); write_byte(8'h07, ack);
        send_bits(8'hF0, 4);
        i2c_stop();
        check("t5_busy", busy, 0);
        check("t5_stb_cnt", stb_cnt, 7);
        i2c_start();
        write_byte(8'h02, ack); write_byte(8'h07, ack);
        write_byte(8'h77, ack); check("t5_ack", ack, 0);
        i2c_stop();
        check("t5_stb_cnt2", stb_cnt, 8);
        check("t5_waddr", log_addr[7], 7);
        check("t5_wdata", log_data[7], 8'h77);
        peek(4'd7, 8'h77, "t5_peek7");

        // reset while driving read bit 7 of 0x33 (a zero)
        i2c_start();
        write_byte(8'h02, ack); write_byte(8'h00, ack);
        i2c_start();
        write_byte(8'h03, ack);
        wait_q();
        check("t6_drive0", SDA, 0);
        rst = 1'b1;
        @(negedge clk);
        check("t6_sda_rel", SDA, 1);
        check("t6_busy", busy, 0);
        rst = 1'b0;
        peek(4'd5, 8'h00, "t6_peek5");
        peek(4'd0, 8'h00, "t6_peek0");
        i2c_stop();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/i2c_slave_regfile.md
Name: i2c_slave_regfile

Overview:
- System-clocked I2C target that replaces direct SCL/SDA edge clocking with oversampled, synchronised bus sampling.
- Holds a parametrised byte register file that the bus can write and read, with multi-byte auto-increment, repeated START and master ACK/NACK on reads.
- Exposes a write-strobe port and a registered host peek port, so the register contents can feed the rest of the measurement datapath.

Parameters:
- SLV_ADDR, 7'h01, 7-bit bus address the block responds to.
- NUM_REGS, 16, number of 8-bit registers (2..256); REG_AW = clog2(NUM_REGS).
- SYNC_STAGES, 2, flip-flop synchroniser depth applied to SCL and SDA (>=2).

Ports:
- clk  input  1  system clock; must run at >= 8x SCL frequency.
- rst  input  1  synchronous, active-high reset.
- SCL  input  1  I2C clock from the master.
- SDA  inout  1  I2C data; open-drain, the block drives 0 or 'z only.
- wr_stb  output  1  one-clk pulse when a bus write commits to a register.
- wr_addr  output  REG_AW  index of the committed register.
- wr_data  output  8  byte committed.
- host_addr  input  REG_AW  host peek index.
- host_rdata  output  8  registered contents of regs[host_addr], 1-clk latency.
- busy  output  1  high from START/repeated START until STOP or return to IDLE.

Behaviour:
- Reset: state=IDLE, all regs=0, reg pointer=0, SDA released ('z), wr_stb=0, wr_addr=0, wr_data=0, host_rdata=0, busy=0. Reset mid-transaction releases SDA on the next clk and ignores the bus until the next START.
- Sampling: SCL and SDA pass through SYNC_STAGES flops, followed by one edge-detect flop. All decisions use the synchronised values.
- START/repeated START: SDA falls while SCL is high. Effect: go to ADDR, clear the bit counter, set busy=1. Valid in any state.
- STOP: SDA rises while SCL is high. Effect: go to IDLE, release SDA, set busy=0. Valid in any state, including mid-byte; a partial byte is discarded with no wr_stb.
- Bit timing: SDA is sampled on the synchronised SCL rising edge. Drive changes (ACK and read data) are applied on the synchronised SCL falling edge. Bytes are MSB first.
- ADDR: shift 7 address bits plus the R/W bit.
  - Address match: drive ACK (SDA=0) for the 9th clock.
  - R/W=0: next state REG.
  - R/W=1: load the shifter from regs[ptr] and enter RDATA.
  - Mismatch: no ACK; go to IDLE (busy=0) and wait for the next START.
- REG: shift 8 bits.
  - If value < NUM_REGS: ACK, ptr := value, next state WDATA.
  - Else: NACK, go to IDLE, ptr unchanged.
- WDATA: shift 8 bits.
  - On the 8th rising edge: regs[ptr] := byte. wr_stb pulses on the following clk with wr_addr=ptr and wr_data=byte.
  - Then ACK, ptr := (ptr+1) mod NUM_REGS, and remain in WDATA for further bytes.
- RDATA: drive the shifter MSB first; bit 7 is driven on the falling edge that ends the address ACK. 1 bits are released ('z), 0 bits are driven low.
  - After 8 bits, release SDA and sample the master ACK on the 9th rising edge.
  - ACK (0): ptr := (ptr+1) mod NUM_REGS, reload, continue in RDATA.
  - NACK (1): go to IDLE, released.
- ACK release: the block releases SDA on the falling edge that ends every ACK slot it drives.
- Combined format: a write of the register byte followed by repeated START and an address with R/W=1 reads from the pointer set by the write phase.
- Pointer wrap: NUM_REGS-1 wraps to 0 for both reads and writes.
- Host port: host_rdata <= regs[host_addr] every clk. If a bus write commits in the same clk, host_rdata returns the old value; the new value appears one clk later.
- Glitches: SDA changes while SCL is low never create START/STOP. Simultaneous SCL and SDA edges within one synchronised sample are resolved using the previous SCL level.

Test Plan:
- Write addr 0x01, reg 0x03, data 0xA5, STOP -> ACK on all three bytes; wr_stb once with wr_addr=3, wr_data=0xA5; host_addr=3 gives 0xA5.
- Write reg 0x0E, data 0x11,0x22,0x33 (NUM_REGS=16) -> regs[14]=0x11, regs[15]=0x22, regs[0]=0x33; three wr_stb pulses; ptr ends at 1.
- Address 0x02 write -> SDA never driven low; busy drops after the address byte; regs unchanged. Reg byte 0x10 -> NACK on the reg byte, no wr_stb.
- Preload regs[5]=0x3C, regs[6]=0xC3; write reg 0x05, repeated START, address 0x01 read, master ACK then NACK -> bus bytes 0x3C then 0xC3; SDA released after the NACK.
- STOP after 4 bits of a data byte -> no wr_stb, busy=0. Next START transaction behaves normally.
- Assert rst during a read while the block drives 0 -> SDA released on the next clk; regs=0; busy=0.
